// File: rtl/debug_scan_master.sv
// debug_scan_master: steps the core and dumps debug registers as a byte stream
// Optional DBG_SCAN_ADDR_TAG_EN prefixes each word with an address tag byte.
module debug_scan_master #(
  parameter logic [6:0] ADDR_FIRST = 7'd0,
  parameter logic [6:0] ADDR_LAST = 7'd63,
  parameter int READ_LAT = 2,
  parameter int STEP_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt_i,
  input  logic        start,
  input  logic        step_req,
  input  logic        dump_after_step,
  output logic        debug_en_o,
  output logic        debug_step_o,
  output logic [6:0]  debug_addr_o,
  input  logic [31:0] debug_data_i,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);
  typedef enum logic [2:0] {IDLE, STEP_HI, STEP_LO, ADDR, WAIT, CAPTURE, SEND, DONE} state_t;
`ifdef DBG_SCAN_ADDR_TAG_EN
  localparam int IW = 3;
  localparam logic [IW-1:0] IDX_TOP = 3'd4;
`else
  localparam int IW = 2;
  localparam logic [IW-1:0] IDX_TOP = 2'd3;
`endif
  localparam int CMAX = STEP_CYCLES > READ_LAT ? STEP_CYCLES : READ_LAT;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [CW-1:0] STEP_END = CW'(STEP_CYCLES - 1);
  localparam logic [CW-1:0] WAIT_END = CW'(READ_LAT > 1 ? READ_LAT - 2 : 0);
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [6:0] addr;
  logic [31:0] capture;
  logic [IW-1:0] idx;
  logic dump_flag, hs, step_go;
  assign hs = tx_valid & tx_ready;
  assign step_go = step_req & debug_en_o;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign debug_step_o = state == STEP_HI;
  assign tx_valid = state == SEND;
`ifdef DBG_SCAN_ADDR_TAG_EN
  assign tx_data = !tx_valid ? 8'h00 : (idx == IDX_TOP) ? {1'b1, addr} : capture[{idx[1:0], 3'b000} +: 8];
`else
  assign tx_data = tx_valid ? capture[{idx, 3'b000} +: 8] : 8'h00;
`endif
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = step_go ? STEP_HI : (start && !step_req) ? ADDR : IDLE;
      STEP_HI: state_nx = (cnt == STEP_END) ? STEP_LO : STEP_HI;
      STEP_LO: state_nx = (cnt != STEP_END) ? STEP_LO : dump_flag ? ADDR : IDLE;
      ADDR:    state_nx = (READ_LAT == 1) ? CAPTURE : WAIT;
      WAIT:    state_nx = (cnt == WAIT_END) ? CAPTURE : WAIT;
      CAPTURE: state_nx = SEND;
      SEND:    state_nx = !(hs && idx == '0) ? SEND : (addr == ADDR_LAST) ? DONE : ADDR;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      addr <= ADDR_FIRST;
      capture <= '0;
      idx <= '0;
      dump_flag <= 1'b0;
      debug_en_o <= 1'b0;
      debug_addr_o <= ADDR_FIRST;
    end else begin
      state <= state_nx;
      debug_en_o <= halt_i;
      // one counter serves both step phases and the read wait; any state change restarts it
      cnt <= (state != state_nx) ? '0 : cnt + 1'b1;
      if (state == IDLE && step_go) dump_flag <= dump_after_step;
      if (state == ADDR) debug_addr_o <= addr;
      if (state == CAPTURE) begin
        capture <= debug_data_i;
        idx <= IDX_TOP;
      end
      if (hs) idx <= idx - 1'b1;
      if (hs && idx == '0 && addr != ADDR_LAST) addr <= addr + 1'b1;
      if (state == DONE) begin
        debug_addr_o <= ADDR_FIRST;
        addr <= ADDR_FIRST;
      end
    end
  end
endmodule

// File: tb/tb_debug_scan_master.sv
// tb_debug_scan_master: directed + randomized checks of debug_scan_master against a byte-stream model
module tb_debug_scan_master;
  localparam logic [6:0] AF = 7'd0;
  localparam logic [6:0] AL = 7'd1;
  localparam int RL = 2;
  localparam int SC = 4;
`ifdef DBG_SCAN_ADDR_TAG_EN
  localparam int BPW = 5;
`else
  localparam int BPW = 4;
`endif
  localparam int WORDS = AL - AF + 1;
  localparam int DUMP_CYC = 1 + WORDS * (1 + RL + BPW);
  logic clk, rst, halt_i, start, step_req, dump_after_step;
  logic debug_en_o, debug_step_o, tx_valid, tx_ready, busy, done;
  logic [6:0] debug_addr_o;
  logic [31:0] debug_data_i, core_q;
  logic [7:0] tx_data;
  logic [31:0] mem [0:127];
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int checks, failures, done_cnt, viol, n, done0;
  logic prev_stall;
  logic [7:0] prev_data;
  logic [9:0] sbits, bbits, sexp, bexp;
  logic vseen;

  debug_scan_master #(.ADDR_FIRST(AF), .ADDR_LAST(AL), .READ_LAT(RL), .STEP_CYCLES(SC)) dut (
    .clk(clk), .rst(rst), .halt_i(halt_i), .start(start), .step_req(step_req),
    .dump_after_step(dump_after_step), .debug_en_o(debug_en_o), .debug_step_o(debug_step_o),
    .debug_addr_o(debug_addr_o), .debug_data_i(debug_data_i), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .done(done));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // core answers one clock after the address changes, so READ_LAT=2 is the shortest that works
  always @(posedge clk) core_q <= mem[debug_addr_o];
  assign debug_data_i = core_q;

  always @(negedge clk) begin
    if (rst) prev_stall = 1'b0;
    else begin
      if (prev_stall && !(tx_valid && tx_data == prev_data)) viol++;
      if (tx_valid && tx_ready) got_q.push_back(tx_data);
      if (done) done_cnt++;
      prev_stall = tx_valid && !tx_ready;
      prev_data = tx_data;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic build_exp();
    exp_q.delete();
    for (int a = AF; a <= AL; a++) begin
`ifdef DBG_SCAN_ADDR_TAG_EN
      exp_q.push_back({1'b1, 7'(a)});
`endif
      for (int b = 3; b >= 0; b--) exp_q.push_back(mem[a][8*b +: 8]);
    end
  endtask

  task automatic cmp_stream(input string tag);
    chk({tag, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
    if (got_q.size() == exp_q.size())
      for (int i = 0; i < exp_q.size(); i++) chk({tag, "_byte"}, 64'(got_q[i]), 64'(exp_q[i]));
  endtask

  task automatic run(input bit rnd, output int cyc);
    cyc = 0;
    while (cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      start = 1'b0; step_req = 1'b0; dump_after_step = 1'b0;
      if (done) break;
      if (rnd) begin
        tx_ready = 1'($urandom_range(0, 1));
        start = ($urandom_range(0, 7) == 0);
        step_req = ($urandom_range(0, 7) == 0);
      end
    end
    chk("done_in_bound", 64'(cyc < 2000), 64'd1);
  endtask

  task automatic wait_valid();
    int k;
    for (k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (tx_valid) break;
    end
    chk("valid_in_bound", 64'(k < 100), 64'd1);
  endtask

  task automatic record_step();
    sbits = '0; bbits = '0; vseen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      step_req = 1'b0; start = 1'b0; dump_after_step = 1'b0;
      sbits[i] = debug_step_o;
      bbits[i] = busy;
      vseen |= tx_valid;
    end
  endtask

  initial begin
    checks = 0; failures = 0; done_cnt = 0; viol = 0;
    rst = 1'b1; halt_i = 1'b0; start = 1'b0; step_req = 1'b0; dump_after_step = 1'b0; tx_ready = 1'b0;
    for (int a = 0; a < 128; a++) mem[a] = 32'hA500_0000 | 32'(a);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(tx_valid), 64'd0);
    chk("rst_data", 64'(tx_data), 64'd0);
    chk("rst_addr", 64'(debug_addr_o), 64'(AF));
    chk("rst_step", 64'(debug_step_o), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    rst = 1'b0; halt_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("en_follows_halt", 64'(debug_en_o), 64'd1);
    #2 rst = 1'b1;
    #1 chk("async_rst_en", 64'(debug_en_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; halt_i = 1'b0;
    // basic dump, ready always high
    build_exp(); got_q.delete(); done0 = done_cnt; tx_ready = 1'b1;
    start = 1'b1;
    run(1'b0, n);
    chk("basic_latency", 64'(n), 64'(DUMP_CYC));
    @(posedge clk); #1;
    chk("basic_busy_after", 64'(busy), 64'd0);
    chk("basic_addr_back", 64'(debug_addr_o), 64'(AF));
    chk("basic_done_once", 64'(done_cnt - done0), 64'd1);
    cmp_stream("basic");
    // backpressure on the byte with index 2
    got_q.delete(); done0 = done_cnt; tx_ready = 1'b0;
    start = 1'b1;
    wait_valid();
    tx_ready = 1'b1;
    repeat (BPW - 3) @(posedge clk);
    #1 tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold", 64'({tx_valid, tx_data}), 64'({1'b1, mem[AF][23:16]}));
    end
    tx_ready = 1'b1;
    run(1'b0, n);
    @(posedge clk); #1;
    chk("bp_done_once", 64'(done_cnt - done0), 64'd1);
    cmp_stream("bp");
    // halted single step
    halt_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 step_req = 1'b1;
    record_step();
    sexp = '0; bexp = '0;
    for (int i = 0; i < 10; i++) begin
      sexp[i] = (i < SC);
      bexp[i] = (i < 2 * SC);
    end
    chk("step_pattern", 64'(sbits), 64'(sexp));
    chk("step_busy", 64'(bbits), 64'(bexp));
    chk("step_no_tx", 64'(vseen), 64'd0);
    // step without halt is ignored
    halt_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 step_req = 1'b1;
    record_step();
    chk("nohalt_step", 64'(sbits), 64'd0);
    chk("nohalt_busy", 64'(bbits), 64'd0);
    // step, start and dump_after_step together
    halt_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    got_q.delete(); done0 = done_cnt;
    step_req = 1'b1; start = 1'b1; dump_after_step = 1'b1;
    run(1'b0, n);
    chk("collide_latency", 64'(n), 64'(2 * SC + DUMP_CYC));
    @(posedge clk); #1;
    chk("collide_done_once", 64'(done_cnt - done0), 64'd1);
    cmp_stream("collide");
    // randomized data, backpressure and stray requests while busy
    for (int it = 0; it < 6; it++) begin
      for (int a = AF; a <= AL; a++) mem[a] = $urandom;
      build_exp(); got_q.delete(); done0 = done_cnt;
      tx_ready = 1'($urandom_range(0, 1));
      start = 1'b1;
      run(1'b1, n);
      tx_ready = 1'b0;
      @(posedge clk); #1;
      chk("rand_idle_after", 64'(busy), 64'd0);
      chk("rand_done_once", 64'(done_cnt - done0), 64'd1);
      cmp_stream("rand");
    end
    // abort during SEND
    got_q.delete(); done0 = done_cnt; tx_ready = 1'b0;
    start = 1'b1;
    wait_valid();
    #2 rst = 1'b1;
    #1;
    chk("abort_valid", 64'(tx_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_data", 64'(tx_data), 64'd0);
    chk("abort_addr", 64'(debug_addr_o), 64'(AF));
    @(posedge clk); #1;
    rst = 1'b0; tx_ready = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("abort_no_done", 64'(done_cnt - done0), 64'd0);
    chk("abort_no_bytes", 64'(got_q.size()), 64'd0);
    chk("abort_idle", 64'(busy), 64'd0);
    // a clean dump still works after the abort
    build_exp(); done0 = done_cnt;
    start = 1'b1;
    run(1'b0, n);
    chk("post_abort_latency", 64'(n), 64'(DUMP_CYC));
    @(posedge clk); #1;
    chk("post_abort_done", 64'(done_cnt - done0), 64'd1);
    cmp_stream("post_abort");
    chk("tx_stable", 64'(viol), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
